// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Round-robin arbiter sharing a single async-FIFO write port among NREQ
//   requesters in the write clock domain. A grant lasts a whole burst. The
//   burst ends on one of three events:
//     - an accepted beat flagged last,
//     - an accepted beat that reaches MAX_BURST beats,
//     - the granted requester dropping req (no write in that cycle).
//   Every write is gated against wfull, so a write into a full FIFO cannot occur.
//
//   Optional feature, FIFO_WR_ARB_STALL_CNT_EN:
//     Adds the stall_clr input and the stall_cnt[15:0] output. stall_cnt is a
//     saturating count of cycles in which the granted requester was held off
//     by wfull. stall_clr clears it synchronously and takes priority over the
//     increment.
//
// Ports
//   wclk      in   write-domain clock
//   wrst      in   asynchronous active-high reset
//   req       in   [NREQ]        per-requester valid, held while data is presented
//   req_last  in   [NREQ]        per-requester last-beat flag, qualified by req
//   req_data  in   [NREQ*DSIZE]  requester i data in bits [i*DSIZE +: DSIZE]
//   req_ack   out  [NREQ]        one-hot, high in the cycle requester i's beat is written
//   gnt       out  [NREQ]        registered one-hot grant, zero when idle
//   busy      out                high while a burst is granted
//   wfull     in                 FIFO full flag (registered in wclk domain)
//   winc      out                FIFO write enable
//   wdata     out  [DSIZE]       FIFO write data
//   stall_clr in                 (macro only) synchronous clear of stall_cnt
//   stall_cnt out  [16]          (macro only) saturating stall-cycle count
module fifo_wr_arb #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  input  logic                  stall_clr,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [PW-1:0]    sel;
  logic             sel_vld;
  logic [DSIZE-1:0] gdata;
  logic             in_burst;
  logic             accept;
  logic             last_beat;
  logic [PW-1:0]    rr_next;

  assign in_burst  = (state_q == BURST);
  assign accept    = in_burst & req[gidx_q] & ~wfull;
  assign last_beat = req_last[gidx_q] | (beat_cnt_q == CW'(MAX_BURST - 1));
  // Explicit wrap so that non-power-of-two NREQ returns to index 0.
  assign rr_next   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

  // First requester at or above rr_ptr_q, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_p;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NR) idx = idx - NR;
      idx_p = PW'(idx);
      if (!sel_vld && req[idx_p]) begin
        sel_vld = 1'b1;
        sel     = idx_p;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gidx_q == PW'(i)) gdata = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d    = BURST;
          gidx_d     = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        // Abandon and accepted-final-beat share one exit path.
        if (!req[gidx_q] || (accept && last_beat)) begin
          state_d    = IDLE;
          gnt_d      = '0;
          rr_ptr_d   = rr_next;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = in_burst;
  assign winc    = accept;
  assign wdata   = in_burst ? gdata : '0;
  assign req_ack = accept ? gnt_q : '0;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (in_burst && req[gidx_q] && wfull && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
